// File: rtl/cfi_alert_ctrl_pkg.sv
// Shared types for the CFI alert controller: violation causes, log entry
// layout, escalation states and the saturating counter helper.
package cfi_alert_ctrl_pkg;

  typedef enum logic [1:0] {
    NONE         = 2'd0,
    JALR_NO_PAD  = 2'd1,
    PAD_NO_JALR  = 2'd2,
    RET_MISMATCH = 2'd3
  } cfi_cause_e;

  typedef struct packed {
    logic [63:0] pc;
    cfi_cause_e  cause;
  } cfi_log_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARN  = 2'd1,
    ALERT = 2'd2
  } cfi_state_e;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  // Add two 8-bit counts, clamping at CNT_MAX instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? CNT_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/cfi_alert_ctrl_if.sv
// Log drain port: the controller presents the oldest logged violation,
// the consumer pops it with log_ready.
interface cfi_alert_ctrl_if;
  import cfi_alert_ctrl_pkg::*;

  logic        log_valid;
  logic        log_ready;
  logic [63:0] log_pc;
  cfi_cause_e  log_cause;

  modport master (output log_valid, output log_pc, output log_cause, input log_ready);
  modport slave  (input log_valid, input log_pc, input log_cause, output log_ready);

endinterface

// File: rtl/cfi_alert_ctrl_log_fifo.sv
// Multi-write, single-read circular log buffer. Up to NR_PORTS compacted
// entries are written per cycle; whatever does not fit is reported as dropped.
module cfi_alert_ctrl_log_fifo
  import cfi_alert_ctrl_pkg::*;
#(
  parameter int NR_PORTS  = 2,
  parameter int LOG_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic [7:0]                 push_cnt_i,
  input  cfi_log_t                   push_data_i [NR_PORTS],
  input  logic                       pop_i,
  output cfi_log_t                   head_o,
  output logic [$clog2(LOG_DEPTH):0] occ_o,
  output logic [7:0]                 drop_cnt_o
);

  localparam int AW = $clog2(LOG_DEPTH);
  localparam int PW = AW + 1;

  cfi_log_t        mem_q [LOG_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            empty, full, pop_eff;
  logic [7:0]      free_slots, n_push;

  // Occupancy, free space and pointer advance; clear empties the buffer and
  // suppresses both push and pop in the same cycle.
  always_comb begin
    empty      = (wr_ptr_q[PW-1] == rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    full       = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    occ_o      = wr_ptr_q - rd_ptr_q;
    pop_eff    = pop_i && !empty && !clear_i;
    free_slots = full ? 8'(pop_eff) : (8'(LOG_DEPTH) - 8'(occ_o) + 8'(pop_eff));
    n_push     = '0;
    drop_cnt_o = '0;
    if (!clear_i) begin
      n_push     = (push_cnt_i > free_slots) ? free_slots : push_cnt_i;
      drop_cnt_o = push_cnt_i - n_push;
    end
    wr_ptr_d = clear_i ? '0 : wr_ptr_q + PW'(n_push);
    rd_ptr_d = clear_i ? '0 : rd_ptr_q + PW'(pop_eff);
    head_o   = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_PORTS; i++) begin
      if (8'(i) < n_push) begin
        mem_q[wr_ptr_q[AW-1:0] + AW'(i)] <= push_data_i[i];
      end
    end
  end

endmodule

// File: rtl/cfi_alert_ctrl.sv
// CFI violation collector: counts accepted violations, logs them for
// software, flags log overflow and escalates to a sticky alert.
module cfi_alert_ctrl
  import cfi_alert_ctrl_pkg::*;
#(
  parameter int NR_PORTS   = 2,
  parameter int LOG_DEPTH  = 4,
  parameter int THRESHOLD  = 3,
  parameter bit LOCK_ALERT = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NR_PORTS-1:0]       viol_valid_i,
  input  logic [NR_PORTS-1:0][63:0] viol_pc_i,
  input  logic [NR_PORTS-1:0][1:0]  viol_cause_i,
  input  logic                      clear_i,
  cfi_alert_ctrl_if.master          log_if,
  output logic [7:0]                viol_count_o,
  output logic                      overflow_o,
  output logic                      alert_o
);

  localparam logic [7:0] TH8 = 8'(THRESHOLD);

  logic [NR_PORTS-1:0]       acc;
  logic [7:0]                acc_cnt;
  cfi_log_t                  push_data [NR_PORTS];
  cfi_log_t                  head;
  logic [$clog2(LOG_DEPTH):0] occ;
  logic [7:0]                drop_cnt;
  logic                      pop;
  int                        seen;

  logic [7:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  cfi_state_e  state_q;

  // Accept legal violations (clear discards them) and count them.
  always_comb begin
    acc     = '0;
    acc_cnt = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      acc[p]  = viol_valid_i[p] && (viol_cause_i[p] != 2'd0) && !clear_i;
      acc_cnt = acc_cnt + 8'(acc[p]);
    end
  end

  // Pack accepted violations into consecutive slots, lowest port first, so
  // the buffer drops from the highest port when space runs out.
  always_comb begin
    seen = 0;
    for (int s = 0; s < NR_PORTS; s++) begin
      push_data[s] = '0;
      seen = 0;
      for (int p = 0; p < NR_PORTS; p++) begin
        if (acc[p]) begin
          if (seen == s) begin
            push_data[s] = '{pc: viol_pc_i[p], cause: cfi_cause_e'(viol_cause_i[p])};
          end
          seen = seen + 1;
        end
      end
    end
  end

  assign pop = (occ != '0) && log_if.log_ready && !clear_i;

  cfi_alert_ctrl_log_fifo #(
    .NR_PORTS  (NR_PORTS),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .push_cnt_i  (acc_cnt),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .occ_o       (occ),
    .drop_cnt_o  (drop_cnt)
  );

  // Next counter and overflow values; clear wins over new violations.
  always_comb begin
    count_d = clear_i ? 8'd0 : sat_add(count_q, acc_cnt);
    ovf_d   = clear_i ? 1'b0 : (ovf_q || (drop_cnt != 8'd0));
  end

  // Counter and sticky overflow registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Escalation FSM; a locked ALERT survives clear and only leaves on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else if (clear_i) begin
      state_q <= (LOCK_ALERT && (state_q == ALERT)) ? ALERT : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_d >= TH8)        state_q <= ALERT;
          else if (count_d != 8'd0)  state_q <= WARN;
        end
        WARN: begin
          if (count_d >= TH8)        state_q <= ALERT;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign viol_count_o     = count_q;
  assign overflow_o       = ovf_q;
  assign alert_o          = (state_q == ALERT);
  assign log_if.log_valid = (occ != '0);
  assign log_if.log_pc    = (occ != '0) ? head.pc : 64'd0;
  assign log_if.log_cause = (occ != '0) ? head.cause : NONE;

endmodule

// File: tb/tb_cfi_alert_ctrl.sv
// Bench for cfi_alert_ctrl: two instances (THRESHOLD 3 locked, THRESHOLD 2
// unlocked) share one stimulus stream and are compared every cycle against
// a queue-based reference model, plus literal expectations for key scenarios.
module tb_cfi_alert_ctrl;
  import cfi_alert_ctrl_pkg::*;

  localparam int NP    = 2;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clear;
  logic                ready;
  logic [NP-1:0]       vv;
  logic [NP-1:0][63:0] vpc;
  logic [NP-1:0][1:0]  vc;

  logic [7:0]  cnt [2];
  logic        ovf [2];
  logic        alr [2];
  logic        lv  [2];
  logic [63:0] lpc [2];
  logic [1:0]  lca [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfi_alert_ctrl_if if_a ();
  cfi_alert_ctrl_if if_b ();

  assign if_a.log_ready = ready;
  assign if_b.log_ready = ready;
  assign lv[0]  = if_a.log_valid;
  assign lpc[0] = if_a.log_pc;
  assign lca[0] = if_a.log_cause;
  assign lv[1]  = if_b.log_valid;
  assign lpc[1] = if_b.log_pc;
  assign lca[1] = if_b.log_cause;

  cfi_alert_ctrl #(.NR_PORTS(NP), .LOG_DEPTH(DEPTH), .THRESHOLD(3), .LOCK_ALERT(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .viol_valid_i(vv), .viol_pc_i(vpc), .viol_cause_i(vc),
    .clear_i(clear), .log_if(if_a), .viol_count_o(cnt[0]), .overflow_o(ovf[0]), .alert_o(alr[0])
  );

  cfi_alert_ctrl #(.NR_PORTS(NP), .LOG_DEPTH(DEPTH), .THRESHOLD(2), .LOCK_ALERT(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .viol_valid_i(vv), .viol_pc_i(vpc), .viol_cause_i(vc),
    .clear_i(clear), .log_if(if_b), .viol_count_o(cnt[1]), .overflow_o(ovf[1]), .alert_o(alr[1])
  );

  // ---------------- reference model ----------------
  int          m_cnt [2];
  bit          m_ovf [2];
  bit          m_alr [2];
  logic [65:0] m_q   [2][$];

  function automatic int th_of(input int k);
    return (k == 0) ? 3 : 2;
  endfunction

  function automatic bit lock_of(input int k);
    return (k == 0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    if (!rst_n) begin
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
      m_alr[k] = 1'b0;
      m_q[k].delete();
    end else if (clear) begin
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
      m_q[k].delete();
      m_alr[k] = lock_of(k) && m_alr[k];
    end else begin
      if (m_q[k].size() > 0 && ready) void'(m_q[k].pop_front());
      for (int p = 0; p < NP; p++) begin
        if (vv[p] && vc[p] != 2'd0) begin
          if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
          if (m_q[k].size() < DEPTH) m_q[k].push_back({vpc[p], vc[p]});
          else m_ovf[k] = 1'b1;
        end
      end
      m_alr[k] = (m_cnt[k] >= th_of(k)) || (lock_of(k) && m_alr[k]);
    end
  endtask

  // Per-cycle compare of both instances against the model.
  initial begin
    logic [63:0] epc;
    logic [1:0]  eca;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
      #1;
      for (int k = 0; k < 2; k++) begin
        epc = (m_q[k].size() > 0) ? m_q[k][0][65:2] : 64'd0;
        eca = (m_q[k].size() > 0) ? m_q[k][0][1:0]  : 2'd0;
        chk($sformatf("model_count[%0d]", k), 64'(cnt[k]), 64'(m_cnt[k]));
        chk($sformatf("model_overflow[%0d]", k), 64'(ovf[k]), 64'(m_ovf[k]));
        chk($sformatf("model_alert[%0d]", k), 64'(alr[k]), 64'(m_alr[k]));
        chk($sformatf("model_valid[%0d]", k), 64'(lv[k]), 64'(m_q[k].size() > 0));
        chk($sformatf("model_pc[%0d]", k), lpc[k], epc);
        chk($sformatf("model_cause[%0d]", k), 64'(lca[k]), 64'(eca));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    vv = '0; vpc = '0; vc = '0; clear = 1'b0; ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; quiet(); cyc(); cyc(); rst_n = 1'b1;
  endtask

  task automatic viol(input int p, input logic [63:0] pc, input logic [1:0] c);
    vv[p] = 1'b1; vpc[p] = pc; vc[p] = c;
  endtask

  initial begin
    logic [63:0] drain_exp [4];
    int phase;
    drain_exp[0] = 64'h1010; drain_exp[1] = 64'h1020;
    drain_exp[2] = 64'h1030; drain_exp[3] = 64'h2000;

    // Reset state
    do_reset();
    chk("rst_count", 64'(cnt[0]), 64'd0);
    chk("rst_valid", 64'(lv[0]), 64'd0);
    chk("rst_alert", 64'(alr[0]), 64'd0);
    chk("rst_overflow", 64'(ovf[0]), 64'd0);
    chk("rst_pc", lpc[0], 64'd0);

    // Single violation
    viol(0, 64'h8000_0010, 2'd1); cyc(); quiet();
    chk("single_count", 64'(cnt[0]), 64'd1);
    chk("single_alert", 64'(alr[0]), 64'd0);
    chk("single_valid", 64'(lv[0]), 64'd1);
    chk("single_pc", lpc[0], 64'h8000_0010);
    chk("single_cause", 64'(lca[0]), 64'd1);
    ready = 1'b1; cyc(); ready = 1'b0;
    chk("single_pop_valid", 64'(lv[0]), 64'd0);

    // Dual-port in one cycle
    do_reset();
    viol(0, 64'h100, 2'd2); viol(1, 64'h104, 2'd3); cyc(); quiet();
    chk("dual_count_b", 64'(cnt[1]), 64'd2);
    chk("dual_alert_b", 64'(alr[1]), 64'd1);
    chk("dual_alert_a", 64'(alr[0]), 64'd0);
    chk("dual_head0", lpc[1], 64'h100);
    ready = 1'b1; cyc(); ready = 1'b0;
    chk("dual_head1", lpc[1], 64'h104);
    chk("dual_head1_cause", 64'(lca[1]), 64'd3);

    // Overflow with ready held low, then full + pop + two pushes
    do_reset();
    for (int i = 0; i < 6; i++) begin
      viol(0, 64'h1000 + 64'(16 * i), 2'd1); cyc(); quiet();
    end
    chk("ovf_count", 64'(cnt[0]), 64'd6);
    chk("ovf_flag", 64'(ovf[0]), 64'd1);
    chk("ovf_head", lpc[0], 64'h1000);
    ready = 1'b1; viol(0, 64'h2000, 2'd1); viol(1, 64'h2004, 2'd2); cyc();
    vv = '0;
    chk("fullpop_count", 64'(cnt[0]), 64'd8);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain_pc%0d", j), lpc[0], drain_exp[j]);
      cyc();
    end
    chk("drain_empty", 64'(lv[0]), 64'd0);
    quiet();

    // Clear collides with a violation while in ALERT
    clear = 1'b1; viol(0, 64'h3000, 2'd1); cyc(); quiet();
    chk("clr_count_a", 64'(cnt[0]), 64'd0);
    chk("clr_count_b", 64'(cnt[1]), 64'd0);
    chk("clr_alert_locked", 64'(alr[0]), 64'd1);
    chk("clr_alert_unlocked", 64'(alr[1]), 64'd0);
    chk("clr_valid_a", 64'(lv[0]), 64'd0);
    chk("clr_overflow_a", 64'(ovf[0]), 64'd0);

    // Saturation, then reset mid-stream with a violation present
    do_reset();
    for (int i = 0; i < 150; i++) begin
      viol(0, 64'h40, 2'd3); viol(1, 64'h44, 2'd2); cyc();
    end
    quiet();
    chk("sat_count_a", 64'(cnt[0]), 64'd255);
    chk("sat_count_b", 64'(cnt[1]), 64'd255);
    viol(0, 64'h5000, 2'd1); rst_n = 1'b0; cyc(); rst_n = 1'b1; quiet();
    chk("midrst_count", 64'(cnt[0]), 64'd0);
    chk("midrst_alert", 64'(alr[0]), 64'd0);
    chk("midrst_valid", 64'(lv[0]), 64'd0);
    chk("midrst_overflow", 64'(ovf[0]), 64'd0);

    // Illegal cause is ignored
    viol(0, 64'h6000, 2'd0); cyc(); quiet();
    chk("illegal_count", 64'(cnt[0]), 64'd0);
    chk("illegal_valid", 64'(lv[0]), 64'd0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      phase = (i / 64) % 4;
      rst_n = ($urandom_range(0, 255) != 0);
      clear = ($urandom_range(0, 63) == 0);
      ready = ($urandom_range(0, 3) < phase);
      for (int p = 0; p < NP; p++) begin
        vv[p]  = ($urandom_range(0, 2) != 0);
        vpc[p] = {$urandom, $urandom};
        vc[p]  = 2'($urandom_range(0, 3));
      end
      cyc();
    end
    quiet(); rst_n = 1'b1; cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfi_alert_ctrl.md
# cfi_alert_ctrl

Downstream consumer of the commit-stage CFI monitor. Takes per-commit-port violation pulses (JALR without landing pad, landing pad not reached by JALR, return mismatch), counts them, buffers the offending PC and cause in a small log FIFO that software or debug drains through a valid/ready port, and runs an escalation FSM that raises a sticky alert once a threshold is reached. It sits between the CFI monitor and the CSR/interrupt logic of the Ariane core.

## Interface
- NR_PORTS, default ariane_pkg::NR_COMMIT_PORTS (2): number of commit ports feeding violations.
- LOG_DEPTH, default 4: log FIFO entries; power of two, ≥ 2.
- THRESHOLD, default 3: violation count at which the alert asserts; range 1..255.
- LOCK_ALERT, default 1: 1 means the ALERT state exits only on reset; 0 means clear_i also exits it.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- viol_valid_i  in  NR_PORTS  one-cycle violation pulse per commit port.
- viol_pc_i  in  NR_PORTS×64  PC of the committing instruction, per port.
- viol_cause_i  in  NR_PORTS×2  cfi_cause_e per port; 2'd0 is illegal and ignored together with its valid.
- clear_i  in  1  software clear of counter, log, overflow and (if unlocked) alert.
- log_valid_o  out  1  log FIFO head is valid.
- log_ready_i  in  1  consumer accepts head; pop when valid && ready.
- log_pc_o  out  64  head PC.
- log_cause_o  out  2  head cause.
- viol_count_o  out  8  saturating violation counter.
- overflow_o  out  1  sticky: at least one violation dropped because the log was full.
- alert_o  out  1  high while the FSM is in ALERT.

## Operation
- Accepted violation: viol_valid_i[p] && viol_cause_i[p] != 0. Up to NR_PORTS per cycle.
- Counter: adds the number of accepted violations each cycle, saturates at 255; never wraps.
- Log push order: port 0 before port 1. Free slots this cycle = LOG_DEPTH − occupancy + (pop ? 1 : 0). Violations beyond free slots are dropped in port order (highest port dropped first) and set overflow_o; they are still counted.
- Pop: log_valid_o && log_ready_i removes the head. Push and pop in the same cycle are legal at any occupancy, including full.
- FSM states: IDLE (count = 0), WARN (0 < count < THRESHOLD), ALERT (count ≥ THRESHOLD).
  - IDLE → WARN when next count ≥ 1 and < THRESHOLD; IDLE → ALERT directly if next count ≥ THRESHOLD (two violations in one cycle with THRESHOLD ≤ 2).
  - WARN → ALERT when next count ≥ THRESHOLD.
  - WARN → IDLE on clear_i.
  - ALERT → IDLE on clear_i only if LOCK_ALERT = 0; otherwise ALERT holds until reset.
- clear_i: counter, FIFO pointers and overflow_o go to 0; violations arriving in the same cycle are discarded (clear wins). With LOCK_ALERT = 1 in ALERT, clear_i still empties the log and the counter, but alert_o stays high.
- Pop during clear_i is ignored; the FIFO is emptied regardless.

## Timing
- Reset (rst_ni low at a clock edge): state IDLE, log_valid_o 0, log_pc_o 0, log_cause_o 0, viol_count_o 0, overflow_o 0, alert_o 0. Reset overrides clear_i and any violation input.
- All outputs are registered. A violation at edge N is visible on viol_count_o, log_valid_o/head and alert_o after edge N.
- Log latency: push to first visibility at head is 1 cycle when empty. The head advances on the edge where valid && ready.
- log_pc_o and log_cause_o are stable while log_valid_o && !log_ready_i.
- No combinational path from any input to any output.

## Structure
- cfi_pkg: cfi_cause_e (NONE = 0, JALR_NO_PAD = 1, PAD_NO_JALR = 2, RET_MISMATCH = 3), cfi_log_t {pc[63:0], cause}, cfi_state_e {IDLE, WARN, ALERT}.
- Sub-module cfi_log_fifo: multi-write (NR_PORTS), single-read circular buffer parameterised by LOG_DEPTH. It takes a push count and entries and returns the head, occupancy and a drop count. Pointers are log2(LOG_DEPTH)+1 bits wide, and full/empty are derived from the MSB difference.
- Top: counter, FSM and overflow flag.

## Test plan
- Single violation: port 0, cause 1, PC 0x8000_0010, THRESHOLD 3 -> next cycle count 1, WARN, log head {0x8000_0010, 1}, alert_o 0. Pop -> log_valid_o 0.
- Dual-port same cycle with THRESHOLD 2: ports 0/1 at PC 0x100/0x104 -> count 2, IDLE→ALERT directly, head 0x100 then 0x104 after one pop.
- Overflow: ready held 0, six violations on port 0 with LOG_DEPTH 4 -> 4 entries kept (first four PCs), overflow_o 1, count 6. Full plus pop plus two pushes in one cycle -> one accepted, one dropped.
- Clear collision: LOCK_ALERT 0, in ALERT, clear_i with a simultaneous violation -> IDLE, count 0, log empty, overflow 0. Same case with LOCK_ALERT 1 -> count 0, log empty, alert_o stays 1.
- Saturation and reset: 300 violations -> count holds 255. Drive rst_ni low mid-stream with a violation present -> all outputs 0 after the edge, and the violation is not logged.
- Illegal cause: valid with cause 0 -> no count change, no log entry.
